// File: rtl/mem_pkg.sv
// Shared definitions for the global memory responder: channel FSM state
// encoding, default widths and the default access latency.
package mem_pkg;

   localparam int DEF_MEM_ADDR_WIDTH = 8;
   localparam int DEF_MEM_DATA_WIDTH = 16;
   localparam int DEF_NUM_MEM_CHAN   = 1;
   localparam int DEF_NUM_DATA_CHAN  = 4;
   localparam int DEF_LATENCY        = 4;

   // Wide enough for any legal latency (1..15).
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } chan_state_e;

endpackage : mem_pkg

// File: rtl/mem_chan_fsm.sv
// One request channel: accepts a read or a write, waits LATENCY cycles,
// performs the array access through the parent, then presents the response.
// Fetch channels use only the read side with the write inputs tied off.
module mem_chan_fsm
   import mem_pkg::*;
#(
   parameter int ADDR_W  = DEF_MEM_ADDR_WIDTH,
   parameter int DATA_W  = DEF_MEM_DATA_WIDTH,
   parameter int LATENCY = DEF_LATENCY
) (
   input  logic              clk,
   input  logic              reset,
   // request side
   input  logic              i_rd_val,
   input  logic [ADDR_W-1:0] i_rd_addr,
   input  logic              i_wr_val,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_rd_rdy,
   output logic              o_wr_rdy,
   // array access (parent owns the array)
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_acc_we,
   output logic [ADDR_W-1:0] o_acc_addr,
   output logic [DATA_W-1:0] o_acc_wdata,
   // response side
   input  logic              i_resp_rdy,
   output logic              o_rd_resp_val,
   output logic [DATA_W-1:0] o_rd_resp_data,
   output logic              o_wr_resp_val
);

   // With LATENCY=1 the access happens on the handshake edge itself.
   localparam bit             IMMEDIATE = (LATENCY == 1);
   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);

   chan_state_e       r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_is_wr;
   logic              r_rd_resp_val;
   logic              r_wr_resp_val;
   logic [DATA_W-1:0] r_resp_data;

   logic              w_idle;
   logic              w_rd_hs;
   logic              w_wr_hs;
   logic [ADDR_W-1:0] w_hs_addr;
   logic              w_wait_done;

   assign w_idle    = (r_state == ST_IDLE);
   // A simultaneous read wins; the write simply stays pending.
   assign w_rd_hs   = w_idle && i_rd_val;
   assign w_wr_hs   = w_idle && i_wr_val && !i_rd_val;
   assign w_hs_addr = w_rd_hs ? i_rd_addr : i_wr_addr;

   // The counter reaches 0 on this edge, so this is the access edge; this
   // places the first response cycle exactly LATENCY cycles after handshake.
   assign w_wait_done = (r_state == ST_WAIT) && (r_cnt == CNT_W'(1));

   assign o_acc_addr  = IMMEDIATE ? w_hs_addr : r_addr;
   assign o_acc_wdata = IMMEDIATE ? i_wr_data : r_wdata;
   // Gated by reset so an in-flight write never commits.
   assign o_acc_we    = !reset && (IMMEDIATE ? w_wr_hs : (w_wait_done && r_is_wr));

   assign o_rd_rdy       = !reset && w_idle;
   assign o_wr_rdy       = !reset && w_idle && !i_rd_val;
   assign o_rd_resp_val  = !reset && r_rd_resp_val;
   assign o_wr_resp_val  = !reset && r_wr_resp_val;
   assign o_rd_resp_data = reset ? '0 : r_resp_data;

   // Channel FSM: IDLE -> WAIT -> RESP -> IDLE with registered response outputs.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every branch
      // below sees the pre-edge values of r_state/r_cnt, like real flops do.
      if (reset) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_is_wr       <= 1'b0;
         r_rd_resp_val <= 1'b0;
         r_wr_resp_val <= 1'b0;
         r_resp_data   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_rd_hs || w_wr_hs) begin
                  r_addr  <= w_hs_addr;
                  r_wdata <= i_wr_data;
                  r_is_wr <= w_wr_hs;
                  r_cnt   <= CNT_LOAD;
                  if (IMMEDIATE) begin
                     r_state       <= ST_RESP;
                     r_rd_resp_val <= w_rd_hs;
                     r_wr_resp_val <= w_wr_hs;
                     if (w_rd_hs) r_resp_data <= i_mem_rdata;
                  end else begin
                     r_state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               r_cnt <= r_cnt - CNT_W'(1);
               if (w_wait_done) begin
                  r_state       <= ST_RESP;
                  r_rd_resp_val <= !r_is_wr;
                  r_wr_resp_val <= r_is_wr;
                  if (!r_is_wr) r_resp_data <= i_mem_rdata;
               end
            end
            ST_RESP: begin
               if (r_is_wr) begin
                  r_wr_resp_val <= 1'b0;
                  r_state       <= ST_IDLE;
               end else if (i_resp_rdy) begin
                  r_rd_resp_val <= 1'b0;
                  r_state       <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule : mem_chan_fsm

// File: rtl/global_mem_responder.sv
// Unified instruction/data memory model: one array shared by all fetch and
// load/store channels, each channel served by its own fixed-latency FSM.
module global_mem_responder
   import mem_pkg::*;
#(
   parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
   parameter int MEM_DATA_WIDTH = DEF_MEM_DATA_WIDTH,
   parameter int NUM_MEM_CHAN   = DEF_NUM_MEM_CHAN,
   parameter int NUM_DATA_CHAN  = DEF_NUM_DATA_CHAN,
   parameter int LATENCY        = DEF_LATENCY
) (
   input  logic                                          clk,
   input  logic                                          reset,
   // fetch channels
   output logic [NUM_MEM_CHAN-1:0]                       fetch_req_rdy,
   input  logic [NUM_MEM_CHAN-1:0]                       fetch_req_val,
   input  logic [NUM_MEM_CHAN-1:0][MEM_ADDR_WIDTH-1:0]   fetch_req_addr,
   input  logic [NUM_MEM_CHAN-1:0]                       fetch_resp_rdy,
   output logic [NUM_MEM_CHAN-1:0]                       fetch_resp_val,
   output logic [NUM_MEM_CHAN-1:0][MEM_DATA_WIDTH-1:0]   fetch_resp_inst,
   // data read channels
   output logic [NUM_DATA_CHAN-1:0]                      read_req_rdy,
   input  logic [NUM_DATA_CHAN-1:0][MEM_ADDR_WIDTH-1:0]  read_req_addr,
   input  logic [NUM_DATA_CHAN-1:0]                      read_req_addr_val,
   input  logic [NUM_DATA_CHAN-1:0]                      read_resp_rdy,
   output logic [NUM_DATA_CHAN-1:0][MEM_DATA_WIDTH-1:0]  read_resp_data,
   output logic [NUM_DATA_CHAN-1:0]                      read_resp_data_val,
   // data write channels
   output logic [NUM_DATA_CHAN-1:0]                      write_req_rdy,
   input  logic [NUM_DATA_CHAN-1:0][MEM_ADDR_WIDTH-1:0]  write_req_addr,
   input  logic [NUM_DATA_CHAN-1:0][MEM_DATA_WIDTH-1:0]  write_req_data,
   input  logic [NUM_DATA_CHAN-1:0]                      write_req_val,
   output logic [NUM_DATA_CHAN-1:0]                      write_resp_val,
   // preload port
   input  logic                                          init_we,
   input  logic [MEM_ADDR_WIDTH-1:0]                     init_addr,
   input  logic [MEM_DATA_WIDTH-1:0]                     init_data
);

   localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

   logic [MEM_DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

   logic [NUM_DATA_CHAN-1:0]                     w_data_we;
   logic [NUM_DATA_CHAN-1:0][MEM_ADDR_WIDTH-1:0] w_data_addr;
   logic [NUM_DATA_CHAN-1:0][MEM_DATA_WIDTH-1:0] w_data_wdata;

   for (genvar f = 0; f < NUM_MEM_CHAN; f++) begin : g_fetch
      logic [MEM_ADDR_WIDTH-1:0] w_addr;
      logic [MEM_DATA_WIDTH-1:0] w_rdata;
      logic                      w_unused_wr_rdy;
      logic                      w_unused_we;
      logic [MEM_DATA_WIDTH-1:0] w_unused_wdata;
      logic                      w_unused_wr_resp;

      assign w_rdata = r_mem[w_addr];

      mem_chan_fsm #(
         .ADDR_W  (MEM_ADDR_WIDTH),
         .DATA_W  (MEM_DATA_WIDTH),
         .LATENCY (LATENCY)
      ) u_chan (
         .clk            (clk),
         .reset          (reset),
         .i_rd_val       (fetch_req_val[f]),
         .i_rd_addr      (fetch_req_addr[f]),
         .i_wr_val       (1'b0),
         .i_wr_addr      ('0),
         .i_wr_data      ('0),
         .o_rd_rdy       (fetch_req_rdy[f]),
         .o_wr_rdy       (w_unused_wr_rdy),
         .i_mem_rdata    (w_rdata),
         .o_acc_we       (w_unused_we),
         .o_acc_addr     (w_addr),
         .o_acc_wdata    (w_unused_wdata),
         .i_resp_rdy     (fetch_resp_rdy[f]),
         .o_rd_resp_val  (fetch_resp_val[f]),
         .o_rd_resp_data (fetch_resp_inst[f]),
         .o_wr_resp_val  (w_unused_wr_resp)
      );
   end

   for (genvar d = 0; d < NUM_DATA_CHAN; d++) begin : g_data
      logic [MEM_DATA_WIDTH-1:0] w_rdata;

      assign w_rdata = r_mem[w_data_addr[d]];

      mem_chan_fsm #(
         .ADDR_W  (MEM_ADDR_WIDTH),
         .DATA_W  (MEM_DATA_WIDTH),
         .LATENCY (LATENCY)
      ) u_chan (
         .clk            (clk),
         .reset          (reset),
         .i_rd_val       (read_req_addr_val[d]),
         .i_rd_addr      (read_req_addr[d]),
         .i_wr_val       (write_req_val[d]),
         .i_wr_addr      (write_req_addr[d]),
         .i_wr_data      (write_req_data[d]),
         .o_rd_rdy       (read_req_rdy[d]),
         .o_wr_rdy       (write_req_rdy[d]),
         .i_mem_rdata    (w_rdata),
         .o_acc_we       (w_data_we[d]),
         .o_acc_addr     (w_data_addr[d]),
         .o_acc_wdata    (w_data_wdata[d]),
         .i_resp_rdy     (read_resp_rdy[d]),
         .o_rd_resp_val  (read_resp_data_val[d]),
         .o_rd_resp_data (read_resp_data[d]),
         .o_wr_resp_val  (write_resp_val[d])
      );
   end

   // Array write port: later assignments win, so the loop order gives the
   // highest data channel priority and the preload port overrides them all.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset branch on purpose; contents survive
      // reset, and a reset on a RAM would prevent block-RAM inference.
      for (int c = 0; c < NUM_DATA_CHAN; c++) begin
         if (w_data_we[c]) r_mem[w_data_addr[c]] <= w_data_wdata[c];
      end
      if (init_we) r_mem[init_addr] <= init_data;
   end

endmodule : global_mem_responder

// File: tb/tb_global_mem_responder.sv
// Directed bench for global_mem_responder at LATENCY=4: reset state, read and
// write latency, held fetch response, write priority, read/write arbitration
// and reset during an in-flight write.
module tb_global_mem_responder;

   localparam int AW = 8;
   localparam int DW = 16;
   localparam int NF = 1;
   localparam int ND = 4;
   localparam int LAT = 4;

   logic clk = 1'b0;
   logic reset;

   logic [NF-1:0]         fetch_req_rdy, fetch_req_val, fetch_resp_rdy, fetch_resp_val;
   logic [NF-1:0][AW-1:0] fetch_req_addr;
   logic [NF-1:0][DW-1:0] fetch_resp_inst;
   logic [ND-1:0]         read_req_rdy, read_req_addr_val, read_resp_rdy, read_resp_data_val;
   logic [ND-1:0][AW-1:0] read_req_addr, write_req_addr;
   logic [ND-1:0][DW-1:0] read_resp_data, write_req_data;
   logic [ND-1:0]         write_req_rdy, write_req_val, write_resp_val;
   logic                  init_we;
   logic [AW-1:0]         init_addr;
   logic [DW-1:0]         init_data;

   int errors = 0;
   int checks = 0;

   global_mem_responder #(
      .MEM_ADDR_WIDTH (AW),
      .MEM_DATA_WIDTH (DW),
      .NUM_MEM_CHAN   (NF),
      .NUM_DATA_CHAN  (ND),
      .LATENCY        (LAT)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .fetch_req_rdy      (fetch_req_rdy),
      .fetch_req_val      (fetch_req_val),
      .fetch_req_addr     (fetch_req_addr),
      .fetch_resp_rdy     (fetch_resp_rdy),
      .fetch_resp_val     (fetch_resp_val),
      .fetch_resp_inst    (fetch_resp_inst),
      .read_req_rdy       (read_req_rdy),
      .read_req_addr      (read_req_addr),
      .read_req_addr_val  (read_req_addr_val),
      .read_resp_rdy      (read_resp_rdy),
      .read_resp_data     (read_resp_data),
      .read_resp_data_val (read_resp_data_val),
      .write_req_rdy      (write_req_rdy),
      .write_req_addr     (write_req_addr),
      .write_req_data     (write_req_data),
      .write_req_val      (write_req_val),
      .write_resp_val     (write_resp_val),
      .init_we            (init_we),
      .init_addr          (init_addr),
      .init_data          (init_data)
   );

   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge.
   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      init_we = 1'b1; init_addr = a; init_data = d;
      next();
      init_we = 1'b0;
   endtask

   // Single read on a data channel with response ready held high.
   task automatic do_read(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] exp,
                          input string tag);
      read_req_addr[ch] = a; read_req_addr_val[ch] = 1'b1; read_resp_rdy[ch] = 1'b1;
      #1 chk1({tag, "_rdy"}, read_req_rdy[ch], 1'b1);
      next();                                   // T+1
      read_req_addr_val[ch] = 1'b0;
      next(); next();                           // T+3
      chk1({tag, "_early"}, read_resp_data_val[ch], 1'b0);
      next();                                   // T+4
      chk1({tag, "_val"}, read_resp_data_val[ch], 1'b1);
      chk16({tag, "_data"}, read_resp_data[ch], exp);
      next();                                   // T+5
      chk1({tag, "_done"}, read_resp_data_val[ch], 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      fetch_req_val = '0; fetch_req_addr = '0; fetch_resp_rdy = '0;
      read_req_addr = '0; read_req_addr_val = '0; read_resp_rdy = '0;
      write_req_addr = '0; write_req_data = '0; write_req_val = '0;
      init_we = 1'b0; init_addr = '0; init_data = '0;

      // ---- reset state ----
      next();
      chk1 ("rst_fetch_rdy", fetch_req_rdy[0], 1'b0);
      chk4 ("rst_read_rdy", read_req_rdy, 4'h0);
      chk4 ("rst_write_rdy", write_req_rdy, 4'h0);
      chk4 ("rst_read_val", read_resp_data_val, 4'h0);
      chk4 ("rst_wresp_val", write_resp_val, 4'h0);
      chk16("rst_read_data0", read_resp_data[0], 16'h0000);
      chk16("rst_inst", fetch_resp_inst[0], 16'h0000);

      // Preload works while reset is held.
      preload(8'h10, 16'hBEEF);
      preload(8'h00, 16'hA5A5);
      preload(8'h30, 16'h0707);
      preload(8'h40, 16'h5555);
      reset = 1'b0;
      #1;
      chk1("post_rst_fetch_rdy", fetch_req_rdy[0], 1'b1);
      chk4("post_rst_read_rdy", read_req_rdy, 4'hF);
      chk4("post_rst_write_rdy", write_req_rdy, 4'hF);
      next();

      // ---- basic read latency: response in T+4 only, ready in T+5 ----
      do_read(0, 8'h10, 16'hBEEF, "rd_beef");
      chk1("rd_beef_rdy_again", read_req_rdy[0], 1'b1);

      // ---- write on ch2: one-cycle response pulse at T+4 ----
      write_req_addr[2] = 8'h20; write_req_data[2] = 16'h1234; write_req_val[2] = 1'b1;
      #1 chk1("wr2_rdy", write_req_rdy[2], 1'b1);
      next();
      write_req_val[2] = 1'b0;
      #1 chk1("wr2_busy", write_req_rdy[2], 1'b0);
      next(); next();
      chk1("wr2_early", write_resp_val[2], 1'b0);
      next();
      chk1("wr2_pulse", write_resp_val[2], 1'b1);
      next();
      chk1("wr2_pulse_end", write_resp_val[2], 1'b0);
      chk1("wr2_rdy_again", write_req_rdy[2], 1'b1);
      do_read(2, 8'h20, 16'h1234, "rd_1234");

      // ---- fetch with response back-pressure for 6 cycles ----
      fetch_req_addr[0] = 8'h00; fetch_req_val[0] = 1'b1; fetch_resp_rdy[0] = 1'b0;
      next();
      fetch_req_val[0] = 1'b0;
      next(); next(); next();                   // T+4
      for (int k = 0; k < 6; k++) begin
         chk1 ("fetch_held_val", fetch_resp_val[0], 1'b1);
         chk16("fetch_held_inst", fetch_resp_inst[0], 16'hA5A5);
         chk1 ("fetch_held_busy", fetch_req_rdy[0], 1'b0);
         next();
      end
      fetch_resp_rdy[0] = 1'b1;
      #1 chk1("fetch_rdy_cycle_val", fetch_resp_val[0], 1'b1);
      next();
      chk1("fetch_done_val", fetch_resp_val[0], 1'b0);
      chk1("fetch_done_rdy", fetch_req_rdy[0], 1'b1);
      fetch_resp_rdy[0] = 1'b0;

      // ---- same-edge writes ch0/ch3 plus a read of the same address ----
      write_req_addr[0] = 8'h30; write_req_data[0] = 16'h1111; write_req_val[0] = 1'b1;
      write_req_addr[3] = 8'h30; write_req_data[3] = 16'h3333; write_req_val[3] = 1'b1;
      read_req_addr[1] = 8'h30; read_req_addr_val[1] = 1'b1; read_resp_rdy[1] = 1'b1;
      #1 chk4("prio_both_rdy", {write_req_rdy[3], write_req_rdy[0], read_req_rdy[1], 1'b1}, 4'hF);
      next();
      write_req_val = '0; read_req_addr_val = '0;
      next(); next(); next();                   // T+4
      chk16("prio_read_old", read_resp_data[1], 16'h0707);
      chk1 ("prio_wr0_pulse", write_resp_val[0], 1'b1);
      chk1 ("prio_wr3_pulse", write_resp_val[3], 1'b1);
      next();
      do_read(1, 8'h30, 16'h3333, "prio_final");

      // ---- read/write collision on ch1: read first, write after ----
      read_req_addr[1] = 8'h10; read_req_addr_val[1] = 1'b1;
      write_req_addr[1] = 8'h50; write_req_data[1] = 16'hCAFE; write_req_val[1] = 1'b1;
      #1;
      chk1("coll_read_rdy", read_req_rdy[1], 1'b1);
      chk1("coll_write_blocked", write_req_rdy[1], 1'b0);
      next();                                   // T+1
      read_req_addr_val[1] = 1'b0;
      next(); next(); next();                   // T+4
      chk1 ("coll_read_val", read_resp_data_val[1], 1'b1);
      chk16("coll_read_data", read_resp_data[1], 16'hBEEF);
      chk1 ("coll_write_wait", write_req_rdy[1], 1'b0);
      next();                                   // T+5: write handshake
      chk1("coll_write_rdy", write_req_rdy[1], 1'b1);
      next();
      write_req_val[1] = 1'b0;
      next(); next(); next();                   // write T+4
      chk1("coll_write_pulse", write_resp_val[1], 1'b1);
      next();
      do_read(1, 8'h50, 16'hCAFE, "coll_write_data");

      // ---- reset during an in-flight write ----
      write_req_addr[2] = 8'h40; write_req_data[2] = 16'hDEAD; write_req_val[2] = 1'b1;
      next();                                   // T+1
      write_req_val[2] = 1'b0;
      next();                                   // T+2
      reset = 1'b1;
      #1;
      chk4("midrst_read_rdy", read_req_rdy, 4'h0);
      chk4("midrst_write_rdy", write_req_rdy, 4'h0);
      chk1("midrst_fetch_rdy", fetch_req_rdy[0], 1'b0);
      next();                                   // T+3
      chk4("midrst_wresp", write_resp_val, 4'h0);
      reset = 1'b0;
      #1;
      chk4("midrst_after_read_rdy", read_req_rdy, 4'hF);
      chk4("midrst_after_write_rdy", write_req_rdy, 4'hF);
      chk1("midrst_after_fetch_rdy", fetch_req_rdy[0], 1'b1);
      for (int k = 0; k < 3; k++) begin
         next();
         chk1("midrst_no_wresp", write_resp_val[2], 1'b0);
      end
      do_read(2, 8'h40, 16'h5555, "midrst_unchanged");

      next();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_global_mem_responder

// File: doc/global_mem_responder.md
GLOBAL_MEM_RESPONDER -- requirements
Module: global_mem_responder

Interface
REQ-001 SHALL take parameter MEM_ADDR_WIDTH, default 8: request address width.
REQ-002 SHALL take parameter MEM_DATA_WIDTH, default 16: data and instruction width.
REQ-003 SHALL take parameter NUM_MEM_CHAN, default 1: number of fetch channels.
REQ-004 SHALL take parameter NUM_DATA_CHAN, default 4: number of load/store channels.
REQ-005 SHALL take parameter LATENCY, default 4 (legal range 1..15): cycles from request handshake to first response-valid cycle.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic rises on posedge clk.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have fetch ports, one entry per fetch channel: fetch_req_rdy out 1; fetch_req_val in 1; fetch_req_addr in MEM_ADDR_WIDTH; fetch_resp_rdy in 1; fetch_resp_val out 1; fetch_resp_inst out MEM_DATA_WIDTH.
REQ-009 SHALL have read ports, one entry per data channel: read_req_rdy out 1; read_req_addr in MEM_ADDR_WIDTH; read_req_addr_val in 1; read_resp_rdy in 1; read_resp_data out MEM_DATA_WIDTH; read_resp_data_val out 1.
REQ-010 SHALL have write ports, one entry per data channel: write_req_rdy out 1; write_req_addr in MEM_ADDR_WIDTH; write_req_data in MEM_DATA_WIDTH; write_req_val in 1; write_resp_val out 1.
REQ-011 SHALL have preload ports: init_we in 1; init_addr in MEM_ADDR_WIDTH; init_data in MEM_DATA_WIDTH. These give direct bench write access.

Function
REQ-012 SHALL hold one unified 2^MEM_ADDR_WIDTH x MEM_DATA_WIDTH array. Fetch and data channels SHALL address the same array.
REQ-013 Each channel SHALL run an independent FSM with states IDLE, WAIT and RESP, and SHALL service one operation at a time.
REQ-014 IDLE: req_rdy=1. A handshake (val&&rdy) in cycle T SHALL latch addr/data, load counter=LATENCY-1 and go to WAIT (or straight to RESP when LATENCY=1).
REQ-015 WAIT: req_rdy=0; the counter SHALL decrement each cycle. On the edge where the counter equals 0, the FSM SHALL perform the array access and go to RESP. First resp_val SHALL therefore be in cycle T+LATENCY.
REQ-016 Data-channel RESP after a read: read_resp_data_val=1 and read_resp_data SHALL be held stable until read_resp_rdy=1; then the FSM SHALL return to IDLE on that edge. Fetch RESP SHALL behave identically using fetch_resp_*.
REQ-017 Data-channel RESP after a write: write_resp_val SHALL pulse for exactly one cycle with no ready, then the FSM SHALL return to IDLE.
REQ-018 If read_req_addr_val and write_req_val are both high in IDLE on one data channel, the read SHALL be accepted. write_req_rdy SHALL equal IDLE && !read_req_addr_val.
REQ-019 A write SHALL commit to the array on its access edge. A read or fetch SHALL sample the array on its access edge and SHALL see pre-edge contents (read-old on a same-edge write).
REQ-020 Same-edge writes to one address SHALL resolve by priority: init_we highest, then data channels by highest index.
REQ-021 init_we SHALL write the array every cycle it is high, independent of the channel FSMs and of reset.
REQ-022 A new request SHALL NOT be accepted in the same cycle a response completes (one cycle in IDLE minimum). Peak rate is one op per LATENCY+1 cycles per channel.
REQ-023 Out-of-range addresses SHALL be impossible: all addresses are full-width and wrap naturally.

Reset
REQ-024 While reset=1, all *_rdy, *_val and write_resp_val outputs SHALL be 0, and read_resp_data and fetch_resp_inst SHALL be 0.
REQ-025 Reset SHALL force every FSM to IDLE and every counter to 0. req_rdy SHALL be 1 in the first cycle after reset falls.
REQ-026 Reset mid-operation SHALL discard in-flight requests. Uncommitted writes SHALL NOT reach the array, and array contents SHALL NOT be cleared.

Structure
REQ-027 Shared package mem_pkg SHALL hold the FSM state encoding (IDLE=0, WAIT=1, RESP=2), default widths and the LATENCY default.
REQ-028 A sub-module mem_chan_fsm (state, counter, latched addr/data, handshake outputs) SHALL be instantiated once per fetch and per data channel. The top level SHALL own the array and write priority.

Verification (LATENCY=4)
REQ-029 Preload addr 0x10=0xBEEF; data ch0 read 0x10 handshake at cycle 10, read_resp_rdy=1 -> read_resp_data_val=1, data 0xBEEF at cycle 14 only; read_req_rdy=1 again at cycle 15.
REQ-030 Ch2 write 0x20=0x1234 at cycle 5 -> write_resp_val pulse at cycle 9 only; a subsequent read of 0x20 returns 0x1234.
REQ-031 Fetch 0x00 (preloaded 0xA5A5) with fetch_resp_rdy held 0 for 6 cycles -> fetch_resp_val held and inst stable at 0xA5A5 throughout; completes on the rdy cycle.
REQ-032 Ch0 and ch3 both write 0x30 in the same cycle (0x1111, 0x3333) -> array holds 0x3333. A read accepted the same cycle as both requests returns the old value.
REQ-033 Ch1 read_req_addr_val and write_req_val both high in IDLE -> read accepted, write_req_rdy=0; the write is accepted after the read response completes.
REQ-034 Reset asserted at cycle 2 of a write in WAIT -> no write_resp_val, target address unchanged, all rdy=1 the cycle after reset falls.
